// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_unit : iterative restoring divider (DIV/DIVU), quotient->LO, rem->HI   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_div_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             valid_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_res_q;
    logic [WIDTH-1:0] rem_res_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    // while quotient bits enter from the bottom.
    always_comb begin
        a_neg = signed_div_i & a_i[WIDTH-1];
        b_neg = signed_div_i & b_i[WIDTH-1];
        abs_a = a_neg ? -a_i : a_i;
        abs_b = b_neg ? -b_i : b_i;
        trial = {rem_q, quo_q[WIDTH-1]};
        fits  = (trial >= {1'b0, dvs_q});
        rem_d = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            valid_q    <= 1'b0;
            dbz_q      <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
        end else if (cancel_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (b_i == '0) begin
                            state_q    <= DONE;
                            valid_q    <= 1'b1;
                            dbz_q      <= 1'b1;
                            quot_res_q <= '1;
                            rem_res_q  <= a_i;
                        end else begin
                            state_q   <= BUSY;
                            cnt_q     <= CW'(WIDTH);
                            rem_q     <= '0;
                            quo_q     <= abs_a;
                            dvs_q     <= abs_b;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        quot_res_q <= neg_quo_q ? -quo_d : quo_d;
                        rem_res_q  <= neg_rem_q ? -rem_d : rem_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o       = ((state_q == IDLE) & start_i & ~cancel_i) | (state_q == BUSY);
    assign valid_o       = valid_q;
    assign div_by_zero_o = dbz_q;
    assign quotient_o    = quot_res_q;
    assign remainder_o   = rem_res_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_unit : self-checking bench for div_unit (WIDTH=32 and WIDTH=8)      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, sg32, cancel32;
    logic [31:0] a32, b32, q32, r32;
    logic        stall32, valid32, dbz32;
    logic        start8, sg8, cancel8;
    logic [7:0]  a8, b8, q8, r8;
    logic        stall8, valid8, dbz8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .signed_div_i(sg32),
        .cancel_i(cancel32), .a_i(a32), .b_i(b32), .stall_o(stall32),
        .valid_o(valid32), .div_by_zero_o(dbz32), .quotient_o(q32), .remainder_o(r32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .signed_div_i(sg8),
        .cancel_i(cancel8), .a_i(a8), .b_i(b8), .stall_o(stall8),
        .valid_o(valid8), .div_by_zero_o(dbz8), .quotient_o(q8), .remainder_o(r8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division on sign-interpreted operands, truncated to w bits.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg,
                         output logic [31:0] q, output logic [31:0] r, output bit dbz);
        longint sa, sb, m, qq, rr;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sb == 0) begin
            q = 32'(m); r = 32'(sa); dbz = 1'b1;
            return;
        end
        dbz = 1'b0;
        if (sg && sa[w-1]) sa -= m + 1;
        if (sg && sb[w-1]) sb -= m + 1;
        qq = sa / sb;
        rr = sa % sb;
        q  = 32'(qq & m);
        r  = 32'(rr & m);
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic sg);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0]; sg8 = sg;
        end else begin
            start32 = s; a32 = a; b32 = b; sg32 = sg;
        end
    endtask

    function automatic logic [31:0] ctrl_of(input int w);
        return (w == 8) ? {29'b0, stall8, valid8, dbz8} : {29'b0, stall32, valid32, dbz32};
    endfunction

    function automatic logic [31:0] q_of(input int w);
        return (w == 8) ? {24'b0, q8} : q32;
    endfunction

    function automatic logic [31:0] r_of(input int w);
        return (w == 8) ? {24'b0, r8} : r32;
    endfunction

    // One full operation: ctrl = {stall, valid, dbz}; inputs are scrambled after acceptance.
    task automatic run_op(input int w, input string tag, input logic [31:0] a,
                          input logic [31:0] b, input bit sg);
        logic [31:0] eq, er;
        bit          ed;
        int          lat;
        model(w, a, b, sg, eq, er, ed);
        lat = ed ? 1 : w + 1;
        @(negedge clk);
        drive(w, 1'b1, a, b, sg);
        #1 check({tag, " ctrl C0"}, ctrl_of(w), 32'b100);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
            #1;
            if (k < lat) begin
                check($sformatf("%s ctrl C%0d", tag, k), ctrl_of(w), 32'b100);
            end else begin
                check($sformatf("%s ctrl C%0d", tag, k), ctrl_of(w), {30'b0, 1'b1, ed});
                check({tag, " quotient"}, q_of(w), eq);
                check({tag, " remainder"}, r_of(w), er);
            end
        end
        @(negedge clk);
        #1;
        check({tag, " ctrl after"}, ctrl_of(w), 32'b0);
        check({tag, " quotient held"}, q_of(w), eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          seen_valid;
        logic [31:0] corner_a [10] = '{32'h80, 32'h7F, 32'h80, 32'hFF, 32'hFF,
                                       32'h00, 32'h05, 32'h81, 32'h7F, 32'h80};
        logic [31:0] corner_b [10] = '{32'hFF, 32'h01, 32'h01, 32'hFF, 32'h01,
                                       32'h05, 32'h00, 32'h00, 32'h80, 32'h80};

        rst_n = 1'b0;
        start32 = 1'b0; sg32 = 1'b0; cancel32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; sg8 = 1'b0; cancel8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("reset ctrl", ctrl_of(32), 32'b0);
        check("reset quotient", q32, 32'h0);
        check("reset remainder", r32, 32'h0);
        rst_n = 1'b1;

        // Directed 32-bit cases
        run_op(32, "divu 100/7", 32'd100, 32'd7, 1'b0);
        run_op(32, "div -7/2", 32'hFFFFFFF9, 32'd2, 1'b1);
        run_op(32, "div 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1);
        run_op(32, "div min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_op(32, "divu 5/0", 32'd5, 32'd0, 1'b0);
        run_op(32, "div -5/0", 32'hFFFFFFFB, 32'd0, 1'b1);
        run_op(32, "divu max/1", 32'hFFFFFFFF, 32'd1, 1'b0);

        // Cancel at C10: no valid, previous result retained
        @(negedge clk);
        drive(32, 1'b1, 32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
            if (k == 10) cancel32 = 1'b1;
        end
        #1 check("cancel C10 ctrl", ctrl_of(32), 32'b100);
        @(negedge clk);
        cancel32 = 1'b0;
        #1 check("cancel C11 ctrl", ctrl_of(32), 32'b0);
        check("cancel quotient kept", q32, 32'hFFFFFFFF);
        check("cancel remainder kept", r32, 32'h0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid |= valid32 | stall32;
        end
        check("cancel no later activity", {31'b0, seen_valid}, 32'b0);
        run_op(32, "divu 9/3 after cancel", 32'd9, 32'd3, 1'b0);

        // cancel and start together: nothing starts
        @(negedge clk);
        drive(32, 1'b1, 32'd50, 32'd5, 1'b0);
        cancel32 = 1'b1;
        #1 check("cancel+start stall", ctrl_of(32), 32'b0);
        @(negedge clk);
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        cancel32 = 1'b0;
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid |= valid32 | stall32;
        end
        check("cancel+start no op", {31'b0, seen_valid}, 32'b0);
        check("cancel+start quotient kept", q32, 32'd3);

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive(32, 1'b1, 32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        rst_n = 1'b0;
        #1 check("midop reset ctrl", ctrl_of(32), 32'b0);
        check("midop reset quotient", q32, 32'h0);
        check("midop reset remainder", r32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid |= valid32;
        end
        check("midop reset no valid", {31'b0, seen_valid}, 32'b0);

        // Back-to-back with start held high
        @(negedge clk);
        drive(32, 1'b1, 32'd100, 32'd7, 1'b0);
        #1 check("b2b ctrl C0", ctrl_of(32), 32'b100);
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            if (k == 1) drive(32, 1'b1, 32'd9, 32'd4, 1'b0);
            if (k == 67) drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
            #1;
            if (k == 33) begin
                check("b2b first ctrl", ctrl_of(32), 32'b010);
                check("b2b first quotient", q32, 32'd14);
                check("b2b first remainder", r32, 32'd2);
            end else if (k == 67) begin
                check("b2b second ctrl", ctrl_of(32), 32'b010);
                check("b2b second quotient", q32, 32'd2);
                check("b2b second remainder", r32, 32'd1);
            end else begin
                check($sformatf("b2b ctrl C%0d", k), ctrl_of(32), 32'b100);
            end
        end
        @(negedge clk);

        // A few random 32-bit operations
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            run_op(32, $sformatf("rand32 #%0d", i), ra, rb, 1'($urandom));
        end

        // WIDTH=8: corners in both modes, then a random sweep
        for (int i = 0; i < 10; i++) begin
            run_op(8, $sformatf("corner8 #%0d s", i), corner_a[i], corner_b[i], 1'b1);
            run_op(8, $sformatf("corner8 #%0d u", i), corner_a[i], corner_b[i], 1'b0);
        end
        for (int i = 0; i < 400; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            run_op(8, $sformatf("rand8 #%0d", i), ra, rb, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
